comparator_serial_nibble: RTL and testbench

//  Sequential magnitude comparator: latches two WIDTH-bit unsigned operands on a start

---
 rtl/comparator_pkg.sv | 16 +
 rtl/cmp_digit.sv | 23 ++
 rtl/comparator_serial_nibble.sv | 152 +++++++++++++++
 tb/tb_comparator_serial_nibble.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the serial nibble comparator.
//   state_e        : FSM state encoding (IDLE=0, CMP=1, DONE=2)
//   WIDTH_DEFAULT  : default operand width in bits
//   DIGIT_DEFAULT  : default slice width compared per cycle
package comparator_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DIGIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit unsigned magnitude comparator.
//   a, b : slice operands
//   l    : a < b
//   e    : a == b
//   g    : a > b
module cmp_digit #(
  parameter int DIGIT = comparator_pkg::DIGIT_DEFAULT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             l,
  output logic             e,
  output logic             g
);

  // Exactly one of the three flags is high for any input pair.
  always_comb begin
    l = (a < b);
    e = (a == b);
    g = (a > b);
  end

endmodule

// File: rtl/comparator_serial_nibble.sv
// Sequential magnitude comparator. Captures a and b on an accepted start,
// compares one DIGIT-bit slice per cycle from the most significant slice
// down, and stops at the first unequal slice.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   en    : block enable; low aborts and forces l/e/g to 0
//   start : launch request, honoured only in IDLE with en high
//   a, b  : WIDTH-bit unsigned operands
//   busy  : high while slices are being compared
//   done  : one-cycle pulse when l/e/g take their new value
//   l/e/g : a<b / a==b / a>b, held until the next accepted start
module comparator_serial_nibble
  import comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              l_q, l_d;
  logic              e_q, e_d;
  logic              g_q, g_d;

  logic [DIGIT-1:0]  a_slice;
  logic [DIGIT-1:0]  b_slice;
  logic              slice_l;
  logic              slice_e;
  logic              slice_g;
  logic              last_slice;

  // Slice mux feeding the single shared digit comparator.
  always_comb begin
    a_slice    = a_q[int'(idx_q)*DIGIT +: DIGIT];
    b_slice    = b_q[int'(idx_q)*DIGIT +: DIGIT];
    last_slice = (idx_q == '0);
  end

  cmp_digit #(
    .DIGIT(DIGIT)
  ) u_cmp_digit (
    .a(a_slice),
    .b(b_slice),
    .l(slice_l),
    .e(slice_e),
    .g(slice_g)
  );

  // State and datapath registers; reset discards any comparison in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
    end
  end

  // Next-state logic. Dropping en returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CMP;
        CMP:     if (!slice_e || last_slice) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, slice index walk and result update.
  // Results are cleared on launch so l/e/g read 0 while busy.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    l_d   = l_q;
    e_d   = e_q;
    g_d   = g_q;
    if (!en) begin
      l_d = 1'b0;
      e_d = 1'b0;
      g_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d   = a;
            b_d   = b;
            idx_d = IDX_TOP;
            l_d   = 1'b0;
            e_d   = 1'b0;
            g_d   = 1'b0;
          end
        end
        CMP: begin
          if (!slice_e) begin
            l_d = slice_l;
            g_d = slice_g;
          end else if (last_slice) begin
            e_d = 1'b1;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by en so an abort is visible in the same cycle.
  always_comb begin
    busy = en && (state_q == CMP);
    done = en && (state_q == DONE);
    l    = en && l_q;
    e    = en && e_q;
    g    = en && g_q;
  end

endmodule

// File: tb/tb_comparator_serial_nibble.sv
// Self-checking bench for comparator_serial_nibble (WIDTH=8, DIGIT=4).
module tb_comparator_serial_nibble;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       l;
  logic       e;
  logic       g;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       l;
    logic       e;
    logic       g;
    int         slices;
  } vec_t;

  comparator_serial_nibble #(
    .WIDTH(8),
    .DIGIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .l(l),
    .e(e),
    .g(g)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge,
  // where outputs are sampled and the next inputs are driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, ".busy"}, int'(busy), 0);
    checkOutput({name, ".done"}, int'(done), 0);
    checkOutput({name, ".l"}, int'(l), 0);
    checkOutput({name, ".e"}, int'(e), 0);
    checkOutput({name, ".g"}, int'(g), 0);
  endtask

  // Drive one start with the given operands and take the accepting edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb);
    en    = 1'b1;
    start = 1'b1;
    a     = va;
    b     = vb;
    step();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Follow one launched comparison until done, checking busy/flags each
  // cycle and the cycle on which done appears (cycle 1 = after accept edge).
  task automatic runVector(input int id, input vec_t v);
    int    done_cycle;
    string tag;
    tag = $sformatf("vec%0d", id);
    applyStimulus(v.a, v.b);
    done_cycle = 0;
    for (int c = 1; c <= 6; c++) begin
      if (done) begin
        done_cycle = c;
        break;
      end
      checkOutput({tag, ".busy"}, int'(busy), 1);
      checkOutput({tag, ".flags_busy"}, int'({l, e, g}), 0);
      step();
    end
    checkOutput({tag, ".done_cycle"}, done_cycle, v.slices + 1);
    checkOutput({tag, ".l"}, int'(l), int'(v.l));
    checkOutput({tag, ".e"}, int'(e), int'(v.e));
    checkOutput({tag, ".g"}, int'(g), int'(v.g));
    step();
    checkOutput({tag, ".done_pulse"}, int'(done), 0);
    checkOutput({tag, ".hold"}, int'({l, e, g}), int'({v.l, v.e, v.g}));
  endtask

  initial begin
    vec_t vecs[10];
    int   dones;

    vecs[0] = '{8'hF0, 8'hFF, 1'b1, 1'b0, 1'b0, 2};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{8'hFF, 8'h7D, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    vecs[6] = '{8'h3A, 8'h3B, 1'b1, 1'b0, 1'b0, 2};
    vecs[7] = '{8'h5C, 8'h5A, 1'b0, 1'b0, 1'b1, 2};
    vecs[8] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1};

    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset for two cycles, then enabled with no start.
    @(negedge clk);
    step();
    step();
    checkIdle("reset");
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkIdle("idle_no_start");
    end

    // Table-driven comparisons.
    for (int i = 0; i < 10; i++) begin
      runVector(i, vecs[i]);
    end

    // Start pulsed while busy is ignored; exactly one done.
    applyStimulus(8'hFF, 8'h7D);
    checkOutput("ign.busy", int'(busy), 1);
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    dones = 0;
    step();
    start = 1'b0;
    checkOutput("ign.done", int'(done), 1);
    checkOutput("ign.g", int'(g), 1);
    checkOutput("ign.l", int'(l), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dones++;
      checkOutput("ign.busy_after", int'(busy), 0);
    end
    checkOutput("ign.extra_dones", dones, 0);
    checkOutput("ign.g_hold", int'(g), 1);

    // Dropping en clears the held result, not just the visible outputs.
    en = 1'b0;
    step();
    checkIdle("en_clear");
    en = 1'b1;
    step();
    checkIdle("en_clear_after");

    // Abort mid-comparison with en=0.
    applyStimulus(8'hF0, 8'hF5);
    checkOutput("abort_en.busy_before", int'(busy), 1);
    en = 1'b0;
    step();
    checkIdle("abort_en");
    en    = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) dones++;
    end
    checkOutput("abort_en.no_activity", dones, 0);
    checkOutput("abort_en.flags", int'({l, e, g}), 0);

    // Same abort using reset.
    applyStimulus(8'hF0, 8'hF5);
    checkOutput("abort_rst.busy_before", int'(busy), 1);
    rst = 1'b1;
    step();
    checkIdle("abort_rst");
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) dones++;
    end
    checkOutput("abort_rst.no_activity", dones, 0);
    checkOutput("abort_rst.flags", int'({l, e, g}), 0);

    // Start held high: relaunch every third cycle, done on cycles 2,5,8.
    en    = 1'b1;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    for (int c = 1; c <= 8; c++) begin
      step();
      checkOutput($sformatf("held.done_c%0d", c), int'(done), (c % 3 == 2) ? 1 : 0);
      checkOutput($sformatf("held.busy_c%0d", c), int'(busy), (c % 3 == 1) ? 1 : 0);
      if (c % 3 == 2) checkOutput($sformatf("held.l_c%0d", c), int'(l), 1);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("held.hold_l", int'(l), 1);
      checkOutput("held.hold_done", int'(done), 0);
      checkOutput("held.hold_busy", int'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
